// File: rtl/fib_bcd_reader.sv
// fib_bcd_reader: sequential binary-to-BCD readout for the Fibonacci result
// register. A start request captures bin_i, then double-dabble runs one bit
// per clock (add 3 to every nibble >= 5, then shift {scratch, shift} left).
// All state changes on the falling edge of clk_i, like the datapath registers.
//
// Optional feature macro: FIB_BCD_BLANK_EN (leading-zero blank flags).
//
// Ports:
//   clk_i    clock, active on the falling edge
//   clr_n_i  asynchronous active-low reset
//   start_i  conversion request, only honoured while idle
//   bin_i    binary value, sampled only at the capture edge
//   busy_o   high while a conversion is in progress
//   done_o   one-cycle pulse when bcd_o/blank_o update
//   bcd_o    packed BCD, most significant digit in the top nibble
//   blank_o  leading-zero flags, bit i for nibble i (all zero without the macro)

module fib_bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  // nibble <= 9 on entry, so +3 never exceeds 12 and needs no carry out
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module fib_bcd_reader #(
  parameter int W      = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  clr_n_i,
  input  logic                  start_i,
  input  logic [W-1:0]          bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     blank_o
);
  localparam int BW = 4*DIGITS;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, CONV} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    sh_q;
  logic [BW-1:0]   scr_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   bcd_q;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   scr_d;
  logic [W-1:0]    sh_d;

  // per-digit add-3 correction
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    fib_bcd_add3 u_add3 (.nib_i(scr_q[4*g +: 4]), .nib_o(adj[4*g +: 4]));
  end

  // one double-dabble step: next MSB of the shift register enters the scratch
  assign {scr_d, sh_d} = {adj, sh_q} << 1;

`ifdef FIB_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              hz;

  // walk down from the top digit; a digit blanks while everything above and
  // itself is zero. Digit 0 is never blanked so a value of 0 shows "0".
  always_comb begin
    blank_d = '0;
    hz      = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      hz         = hz & (scr_d[4*i +: 4] == 4'd0);
      blank_d[i] = hz;
    end
  end

  assign blank_o = blank_q;
`else
  assign blank_o = '0;
`endif

  always_ff @(negedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef FIB_BCD_BLANK_EN
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sh_q    <= bin_i;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          sh_q  <= sh_d;
          scr_q <= scr_d;
          cnt_q <= cnt_q + 1'b1;
          // last bit shifted in this edge: publish and drop busy
          if (cnt_q == CW'(W-1)) begin
            bcd_q   <= scr_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef FIB_BCD_BLANK_EN
            blank_q <= blank_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_fib_bcd_reader.sv
// Bench for fib_bcd_reader: directed vectors, expected results pushed into a
// scoreboard queue at start time, popped by a monitor on every done pulse.
// The DUT acts on the falling edge; the bench drives and samples on the rising edge.
module tb_fib_bcd_reader;
  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [11:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
  } exp_t;
  exp_t sb[$];

  fib_bcd_reader #(.W(12), .DIGITS(4)) dut (
    .clk_i  (clk),
    .clr_n_i(clr_n),
    .start_i(start),
    .bin_i  (bin),
    .busy_o (busy),
    .done_o (done),
    .bcd_o  (bcd),
    .blank_o(blank)
  );

  always #5 clk = ~clk;

  // blank flags only exist with the macro; otherwise they read as zero
  function automatic logic [3:0] bl(input logic [3:0] x);
`ifdef FIB_BCD_BLANK_EN
    return x;
`else
    return 4'b0000 & x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd", 32'(bcd), 32'(e.bcd));
        chk("blank", 32'(blank), 32'(e.blank));
      end
    end
  end

  // one conversion; chg_k/pulse_k select the edge index at which bin changes
  // or a stray start pulse is presented (out of range = never)
  task automatic conv(input logic [11:0] v, input logic [15:0] e_bcd, input logic [3:0] e_bl,
                      input int chg_k, input logic [11:0] chg_v, input int pulse_k);
    @(posedge clk);
    start = 1'b1;
    bin   = v;
    sb.push_back('{e_bcd, bl(e_bl)});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      chk("busy_conv", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      start = (k == pulse_k);
      if (k == chg_k) bin = chg_v;
    end
    @(posedge clk);
    chk("busy_end", 32'(busy), 32'd0);
    chk("done_at_ew", 32'(done), 32'd1);
    start = 1'b0;
    @(posedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_blank", 32'(blank), 32'(bl(4'b1110)));
    clr_n = 1'b1;
    // idle without a capture never pulses done
    repeat (3) begin
      @(posedge clk);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    conv(12'd0,    16'h0000, 4'b1110, 99, 12'd0, 99);
    conv(12'd4095, 16'h4095, 4'b0000, 99, 12'd0, 99);
    // bin changed mid-conversion and a stray start: both ignored
    conv(12'd144,  16'h0144, 4'b1000, 3, 12'd7, 5);
    chk("bcd_hold", 32'(bcd), 32'h0144);

    // start held high: back-to-back conversions, W+1 cycles apart
    @(posedge clk);
    start = 1'b1;
    bin   = 12'd233;
    sb.push_back('{16'h0233, bl(4'b1000)});
    @(posedge clk);
    bin = 12'd377;
    chk("held_busy1", 32'(busy), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk);
      chk("held_busy1", 32'(busy), 32'd1);
    end
    @(posedge clk);
    chk("held_done1", 32'(done), 32'd1);
    chk("held_idle", 32'(busy), 32'd0);
    sb.push_back('{16'h0377, bl(4'b1000)});
    @(posedge clk);
    start = 1'b0;
    chk("held_busy2", 32'(busy), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk);
      chk("held_busy2", 32'(busy), 32'd1);
      chk("held_done_early", 32'(done), 32'd0);
    end
    @(posedge clk);
    chk("held_done2", 32'(done), 32'd1);
    chk("held_end", 32'(busy), 32'd0);

    // reset mid-conversion aborts with no done
    conv(12'd89, 16'h0089, 4'b1100, 99, 12'd0, 99);
    @(posedge clk);
    start = 1'b1;
    bin   = 12'd610;
    @(posedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1 clr_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_blank", 32'(blank), 32'(bl(4'b1110)));
    repeat (3) begin
      @(posedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    clr_n = 1'b1;
    @(posedge clk);
    conv(12'd610, 16'h0610, 4'b1000, 99, 12'd0, 99);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fib_bcd_reader.md
# fib_bcd_reader

Sequential binary-to-BCD readout for the Fibonacci processor's 12-bit result register. On a start request it captures the register's output, converts it to packed BCD digits by iterative shift-and-add-3, one bit per clock, and presents the digits with a completion pulse for the display/output stage. It sits on the read side of the 12-bit result register, between that register's `q` and the seven-segment/output logic.

## Interface
- `W`, 12, binary input width in bits.
- `DIGITS`, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^W − 1.
- `clk`  in  1  clock; all state changes on the falling edge, matching the datapath registers.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  conversion request, sampled on the falling edge of `clk`.
- `bin`  in  W  binary value to convert, normally the result register `q`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bcd` is updated.
- `bcd`  out  4*DIGITS  packed BCD result, most significant digit in the top nibble.
- `blank`  out  DIGITS  leading-zero blank flags, one per digit, bit i for nibble i.

## Operation
- FSM states:
  - IDLE: `busy` = 0.
  - CONV: `busy` = 1; holds bit counter `cnt` and working registers (shift register of width W, scratch BCD of width 4*DIGITS).
- IDLE with `start` = 1 at an edge → capture `bin` into the shift register, clear the scratch BCD, set `cnt` = 0, go to CONV.
- IDLE with `start` = 0 → stay in IDLE.
- CONV, each edge:
  - Every scratch nibble ≥ 5 gets +3.
  - Then {scratch, shift} shifts left by one.
  - `cnt` increments.
- On the iteration with `cnt` = W−1:
  - Load the final scratch value into `bcd`.
  - Pulse `done` = 1.
  - Return to IDLE with `busy` = 0.
- `start` in CONV is ignored; there is no queuing.
- `bin` is sampled only at the capture edge. Later changes to `bin` do not affect the conversion in progress.
- `bcd` and `blank` hold the last completed result until the next completion. They are not cleared at start.
- Arithmetic:
  - Nibble add-3 is 4-bit with no carry out, since a nibble ≥ 5 plus 3 is ≤ 12.
  - Output nibbles are always 0–9.
- Reset (`clr_n` = 0, any time, including mid-conversion):
  - State → IDLE, `busy` = 0, `done` = 0, `bcd` = 0.
  - `blank` = reset value (see Configuration).
  - Working registers = 0.
  - An aborted conversion produces no `done`.

## Timing
- Capture edge E0: `busy` rises after E0.
- Iteration edges E1..EW. At EW: `bcd` is valid, `done` = 1 for exactly one cycle, `busy` falls.
- Latency from start-accepting edge to `done` is W edges (12 at default).
- `start` held high continuously:
  - At EW the FSM is still busy, so `start` is ignored.
  - The next conversion is captured at EW+1.
  - Back-to-back throughput is one result per W+1 cycles.
- `done` never asserts while `clr_n` = 0 or in IDLE without a preceding capture.

## Configuration
- Macro `FIB_BCD_BLANK_EN`:
  - Defined:
    - `blank[i]` = 1 when nibble i and all higher nibbles are 0, except `blank[0]`, which is always 0.
    - Updated at the same edge as `bcd`.
    - Reset value is all ones except bit 0 (4'b1110 at default), so the display shows "0".
  - Undefined: `blank` is tied to all zeros, and no blanking logic is present.

## Test plan
- Reset, then `bin` = 0 with a one-cycle `start` → `busy` high for 12 cycles, `done` pulse at E12, `bcd` = 0x0000. With the macro, `blank` = 4'b1110.
- `bin` = 4095 with `start` → `bcd` = 0x4095 at E12. With the macro, `blank` = 4'b0000.
- `bin` = 144 with `start`; `bin` changed to 7 at E3 → `bcd` = 0x0144 at E12. With the macro, `blank` = 4'b1000. `start` pulsed at E5 is ignored, so there is only one `done`.
- `bin` = 233 with `start` held high, switching `bin` to 377 after E0 → `done` at E12 with `bcd` = 0x0233. Second capture at E13, `done` at E25 with `bcd` = 0x0377.
- Complete a conversion of 89, then start `bin` = 610 and drop `clr_n` low at E6 → immediate `busy` = 0, `bcd` = 0, no `done`. After release, a new start of 610 yields `bcd` = 0x0610 after 12 cycles.
